// File: rtl/data_cal_ctrl_if.sv
// Handshake bundle tying data_cal_ctrl to its two requesters, the data_cal datapath
// and the response consumer. The controller side uses the master modport.
interface data_cal_ctrl_if;
    logic        req_valid_a;
    logic [15:0] req_d_a;
    logic        req_ready_a;
    logic        req_valid_b;
    logic [15:0] req_d_b;
    logic        req_ready_b;

    logic [15:0] cal_d;
    logic [1:0]  cal_sel;
    logic        cal_en;
    logic [4:0]  cal_out;
    logic        cal_validout;

    logic        res_valid;
    logic        res_ready;
    logic [19:0] res_data;
    logic        res_id;
    logic        res_err;
    logic        busy;

    modport master (
        input  req_valid_a, req_d_a, req_valid_b, req_d_b,
        input  cal_out, cal_validout, res_ready,
        output req_ready_a, req_ready_b,
        output cal_d, cal_sel, cal_en,
        output res_valid, res_data, res_id, res_err, busy
    );

    modport slave (
        output req_valid_a, req_d_a, req_valid_b, req_d_b,
        output cal_out, cal_validout, res_ready,
        input  req_ready_a, req_ready_b,
        input  cal_d, cal_sel, cal_en,
        input  res_valid, res_data, res_id, res_err, busy
    );
endinterface

// File: rtl/data_cal_ctrl.sv
// Round-robin front end for the shared data_cal datapath: steps one accepted word through
// all four sel codes, packs the results and holds them until the consumer takes them.
module data_cal_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 8
) (
    input  logic            clk,
    input  logic            rst,
    data_cal_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            last_grant;
    logic [1:0]      idx;
    logic [TW-1:0]   wd;
    logic [3:0][4:0] slots;
    logic [15:0]     cal_d_q;
    logic            res_id_q;
    logic            res_err_q;

    logic            grant_a;
    logic            grant_b;
    logic            accept;
    logic            wd_expire;

    // last_grant == 1 means B was served last, so A wins the next tie
    assign grant_a   = (state == IDLE) && bus.req_valid_a && (!bus.req_valid_b || last_grant);
    assign grant_b   = (state == IDLE) && bus.req_valid_b && (!bus.req_valid_a || !last_grant);
    assign accept    = grant_a || grant_b;
    assign wd_expire = (wd == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                // a result arriving on the expiry cycle still wins over the abort
                if (bus.cal_validout) begin
                    state_next = (idx == 2'd3) ? DONE : ISSUE;
                end else if (wd_expire) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.req_ready_a = grant_a;
        bus.req_ready_b = grant_b;
        bus.cal_en      = (state == ISSUE);
        bus.res_valid   = (state == DONE);
        bus.busy        = (state != IDLE);
    end

    assign bus.cal_d    = cal_d_q;
    assign bus.cal_sel  = idx;
    assign bus.res_data = slots;
    assign bus.res_id   = res_id_q;
    assign bus.res_err  = res_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            idx        <= 2'd0;
            wd         <= '0;
            slots      <= '0;
            cal_d_q    <= 16'd0;
            res_id_q   <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cal_d_q    <= grant_a ? bus.req_d_a : bus.req_d_b;
                        res_id_q   <= grant_b;
                        last_grant <= grant_b;
                        idx        <= 2'd0;
                        slots      <= '0;
                        res_err_q  <= 1'b0;
                    end
                end
                ISSUE: begin
                    wd <= '0;
                end
                WAIT: begin
                    if (bus.cal_validout) begin
                        slots[idx] <= bus.cal_out;
                        if (idx != 2'd3) begin
                            idx <= idx + 2'd1;
                        end
                    end else if (wd_expire) begin
                        res_err_q <= 1'b1;
                    end else begin
                        wd <= wd + TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/data_cal_ctrl.md
# data_cal_ctrl

Sequencing and arbitration controller for the shared `data_cal` nibble-sum datapath. Two requesters each submit a 16-bit word through a valid/ready handshake, and a round-robin arbiter picks one. The controller then drives the datapath through all four `sel` codes, one at a time, waiting for each `validout`. It packs the four 5-bit results into one 20-bit response, which is held until the consumer accepts it. A watchdog aborts any step whose `validout` never arrives.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum WAIT cycles per step before abort (1..255).
- `TW`, default 8: width of the watchdog counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid_a`  in  1  requester A word valid.
- `req_d_a`  in  16  requester A word.
- `req_ready_a`  out  1  A accepted this cycle when `req_valid_a` is also high.
- `req_valid_b`, `req_d_b`, `req_ready_b`: same as A, for requester B.
- `cal_d`  out  16  word driven to datapath `d`.
- `cal_sel`  out  2  datapath `sel`.
- `cal_en`  out  1  one-cycle issue strobe to datapath.
- `cal_out`  in  5  datapath result.
- `cal_validout`  in  1  datapath result valid.
- `res_valid`  out  1  response valid.
- `res_ready`  in  1  consumer ready.
- `res_data`  out  20  {slot3, slot2, slot1, slot0}, 5 bits each, slot n = result for `sel` = n.
- `res_id`  out  1  0 = requester A, 1 = requester B.
- `res_err`  out  1  response aborted by timeout.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE arbitration:**
  - `req_ready_x` is combinational and high only in IDLE.
  - If only one requester is valid, it gets ready.
  - If both are valid, the requester not granted last time wins.
  - `last_grant` resets to B, so A wins the first tie.
- **Accept (valid & ready):**
  - Capture the word into `cal_d`.
  - Set `res_id`, update `last_grant`.
  - Clear `idx`, all slots, and `res_err`.
  - Go to ISSUE.
- **ISSUE:**
  - `cal_en` = 1 for exactly one cycle, with `cal_sel` = `idx`.
  - Clear the watchdog and go to WAIT.
  - `cal_d` and `cal_sel` stay stable until the next ISSUE or the next accept.
- **WAIT:**
  - The watchdog increments each cycle.
  - On `cal_validout`: slot[`idx`] <= `cal_out`.
  - If `idx` = 3, go to DONE; otherwise `idx` += 1 and go to ISSUE.
  - If the watchdog reaches `TIMEOUT` with no `cal_validout`: set `res_err` = 1 and go to DONE. Uncaptured slots remain 0.
  - `cal_validout` in the same cycle the watchdog reaches `TIMEOUT` counts as a capture; no error.
- **Stray `cal_validout`:** ignored in IDLE, ISSUE and DONE.
- **DONE:**
  - `res_valid` = 1; `res_data`, `res_id` and `res_err` are held stable.
  - On `res_ready`, go to IDLE. `res_valid` drops the next cycle.
  - No new request is accepted before DONE exits.
- **Arithmetic:** the controller never modifies `cal_out`; slots are stored verbatim, 5 bits each.

## Timing
- **Reset values:** every output is 0, state = IDLE, `last_grant` = B, slots cleared.
- **Reset mid-operation:** `rst` asserted in any state forces the reset values immediately (asynchronous). Any in-flight datapath result is dropped.
- **Accept:** the accept edge is cycle 0; ISSUE occupies cycle 1.
- **Step length:** if the datapath asserts `cal_validout` L cycles after sampling `cal_en`, each step takes L+1 cycles.
- **First `res_valid`:** cycle 4(L+1)+1.
- **Throughput:** back-to-back requests have a minimum 1-cycle IDLE gap after the DONE handshake.
- **Abort latency:** a timeout response appears `TIMEOUT`+1 cycles after the failing issue.

## Test plan
The bench uses a behavioural datapath with L = 2, computing `sel`=0 -> d[3:0] and `sel`=n -> d[3:0] + d[4n+3:4n], each 5 bits.
1. **Single A request:** A sends 16'h4321, `res_ready` = 1 -> `res_valid` rises at cycle 13; `res_data` = {5'd5, 5'd4, 5'd3, 5'd1}; `res_id` = 0; `res_err` = 0; `cal_sel` sequence 0, 1, 2, 3 at cycles 1, 4, 7, 10.
2. **Overflow:** B sends 16'hFFFF -> `res_data` = {5'h1E, 5'h1E, 5'h1E, 5'h0F}; `res_id` = 1.
3. **Simultaneous requests:** A and B held valid continuously -> grants alternate A, B, A, B starting with A; each `req_ready` pulses once per grant.
4. **Backpressure:** `res_ready` held 0 for 10 cycles in DONE -> `res_valid` and `res_data` stable throughout; both `req_ready` signals stay 0; the pending request is accepted the cycle after the DONE exit.
5. **Timeout:** model suppresses `validout` for `sel`=2 with `TIMEOUT`=15 -> `res_err` = 1; slots 0 and 1 correct; slots 2 and 3 = 0; `res_valid` appears 16 cycles after the `sel`=2 issue.
6. **Reset mid-operation:** `rst` pulses during WAIT of `sel`=1 -> all outputs 0 immediately; the next tie is granted to A; the following request completes normally.
